// File: rtl/cmp_req_ctrl.sv
// Compare-request controller: takes a compare request, pulses the ALU compare unit once,
// waits for its registered flag (with timeout) and returns a boolean verdict.
module cmp_req_ctrl #(
    parameter int WIDTH   = 16,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    output logic [3:0]       cmp_fun,
    output logic             cmp_en,
    input  logic [RES_W-1:0] cmp_res,
    input  logic             cmp_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_true,
    output logic             rsp_err,
    output logic [7:0]       op_cnt
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nx;
    logic [1:0]       op_q, op_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [WIDTH-1:0] a_nx, b_nx;
    logic [3:0]       fun_nx;
    logic             en_nx, vld_nx, true_nx, err_nx;
    logic [7:0]       cnt_nx;
    logic [RES_W-1:0] exp_code;

    function automatic logic [3:0] fun_of(input logic [1:0] op);
        case (op)
            2'd0:    return 4'b1001;
            2'd1:    return 4'b1010;
            2'd2:    return 4'b1011;
            default: return 4'b0000;
        endcase
    endfunction

    // ALU reports 1/2/3 when the EQ/GT/LT relation holds, i.e. op+1
    assign exp_code  = RES_W'(op_q) + RES_W'(1);
    assign req_ready = (state == IDLE);

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        timer_nx = timer;
        a_nx     = cmp_a;
        b_nx     = cmp_b;
        fun_nx   = 4'b0000;
        en_nx    = 1'b0;
        vld_nx   = rsp_valid;
        true_nx  = rsp_true;
        err_nx   = rsp_err;
        cnt_nx   = op_cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_nx = req_op;
                    if (req_op == 2'd3) begin
                        state_nx = RESP;
                        vld_nx   = 1'b1;
                        true_nx  = 1'b0;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = ISSUE;
                        a_nx     = req_a;
                        b_nx     = req_b;
                        fun_nx   = fun_of(req_op);
                        en_nx    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nx = WAIT;
                timer_nx = '0;
            end
            WAIT: begin
                if (cmp_flag) begin
                    state_nx = RESP;
                    vld_nx   = 1'b1;
                    true_nx  = (cmp_res == exp_code);
                    err_nx   = (cmp_res != exp_code) && (cmp_res != '0);
                end else if (timer == T_LAST) begin
                    state_nx = RESP;
                    vld_nx   = 1'b1;
                    true_nx  = 1'b0;
                    err_nx   = 1'b1;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                    vld_nx   = 1'b0;
                    true_nx  = 1'b0;
                    err_nx   = 1'b0;
                    if (!rsp_err) cnt_nx = op_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= '0;
            timer     <= '0;
            cmp_a     <= '0;
            cmp_b     <= '0;
            cmp_fun   <= '0;
            cmp_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_true  <= 1'b0;
            rsp_err   <= 1'b0;
            op_cnt    <= '0;
        end else begin
            state     <= state_nx;
            op_q      <= op_nx;
            timer     <= timer_nx;
            cmp_a     <= a_nx;
            cmp_b     <= b_nx;
            cmp_fun   <= fun_nx;
            cmp_en    <= en_nx;
            rsp_valid <= vld_nx;
            rsp_true  <= true_nx;
            rsp_err   <= err_nx;
            op_cnt    <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_cmp_req_ctrl.sv
// Bench for cmp_req_ctrl: behavioural ALU with programmable flag delay / result corruption,
// directed scenarios plus randomized requests checked against an outcome-level model.
`timescale 1ns/1ps
module tb_cmp_req_ctrl;
    localparam int WIDTH = 16, RES_W = 16, TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0, req_ready;
    logic [WIDTH-1:0] req_a = '0, req_b = '0;
    logic [1:0]       req_op = '0;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic [3:0]       cmp_fun;
    logic             cmp_en;
    logic [RES_W-1:0] cmp_res;
    logic             cmp_flag;
    logic             rsp_valid, rsp_ready = 1'b0, rsp_true, rsp_err;
    logic [7:0]       op_cnt;

    int total = 0, bad = 0;
    int ref_cnt = 0;
    int alu_delay = 0;   // -1: flag never raised
    int alu_force = -1;  // >=0: ALU returns this code regardless of operands

    cmp_req_ctrl #(.WIDTH(WIDTH), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_fun(cmp_fun), .cmp_en(cmp_en), .cmp_res(cmp_res), .cmp_flag(cmp_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_true(rsp_true),
        .rsp_err(rsp_err), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [RES_W-1:0] alu_out(input logic [3:0] f, input logic [WIDTH-1:0] a, b,
                                                 input int force_code);
        if (force_code >= 0) return RES_W'(force_code);
        case (f)
            4'b1001: return (a == b) ? RES_W'(1) : RES_W'(0);
            4'b1010: return (a > b)  ? RES_W'(2) : RES_W'(0);
            4'b1011: return (a < b)  ? RES_W'(3) : RES_W'(0);
            default: return RES_W'(0);
        endcase
    endfunction

    // Registered ALU compare unit
    logic             armed;
    int               ctr;
    logic [RES_W-1:0] code_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_flag <= 1'b0; cmp_res <= '0; armed <= 1'b0; ctr <= 0; code_q <= '0;
        end else begin
            cmp_flag <= 1'b0;
            if (cmp_en) begin
                if (alu_delay == 0) begin
                    cmp_flag <= 1'b1;
                    cmp_res  <= alu_out(cmp_fun, cmp_a, cmp_b, alu_force);
                end else if (alu_delay > 0) begin
                    armed  <= 1'b1;
                    ctr    <= alu_delay - 1;
                    code_q <= alu_out(cmp_fun, cmp_a, cmp_b, alu_force);
                end
            end else if (armed) begin
                if (ctr == 0) begin
                    cmp_flag <= 1'b1; cmp_res <= code_q; armed <= 1'b0;
                end else ctr <= ctr - 1;
            end
        end
    end

    // Outcome-level reference: what the requester should see for one request
    task automatic predict(input logic [WIDTH-1:0] a, b, input logic [1:0] op, input int dly,
                           input int frc, output logic t, output logic e, output int lat);
        int code;
        t = 1'b0; e = 1'b0;
        if (op == 2'd3) begin
            e = 1'b1; lat = 1;
        end else if (dly < 0 || dly >= TIMEOUT) begin
            e = 1'b1; lat = 2 + TIMEOUT;
        end else begin
            lat = 3 + dly;
            if (frc >= 0) code = frc;
            else if (op == 2'd0) code = (a == b) ? 1 : 0;
            else if (op == 2'd1) code = (a > b) ? 2 : 0;
            else code = (a < b) ? 3 : 0;
            if (code == op + 1) t = 1'b1;
            else if (code != 0) e = 1'b1;
        end
    endtask

    function automatic logic [3:0] exp_fun(input logic [1:0] op);
        return (op == 2'd3) ? 4'd0 : 4'b1001 + 4'(op);
    endfunction

    // Drive one request and observe it; lat = -1 if no response in budget
    task automatic run_op(input logic [WIDTH-1:0] a, b, input logic [1:0] op, input bit keep_req,
                          input int hold, output int lat, output logic t, output logic e,
                          output int pulses, output logic [3:0] fun, output logic [WIDTH-1:0] sa,
                          output logic [WIDTH-1:0] sb, output bit stable);
        int w = 0;
        lat = -1; pulses = 0; fun = '0; sa = '0; sb = '0; stable = 1'b1; t = 1'b0; e = 1'b0;
        @(negedge clk);
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (!keep_req) req_valid = 1'b0;
            if (cmp_en) begin pulses++; fun = cmp_fun; sa = cmp_a; sb = cmp_b; end
            if (rsp_valid) begin lat = c; break; end
        end
        t = rsp_true; e = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_true !== t || rsp_err !== e || req_ready) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (req_ready !== 1'b1 || cmp_en !== 1'b0 || cmp_fun !== 4'd0 || cmp_a !== '0 ||
            cmp_b !== '0 || rsp_valid !== 1'b0 || rsp_true !== 1'b0 || rsp_err !== 1'b0 ||
            op_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b en=%b fun=%h a=%h b=%h vld=%b t=%b e=%b cnt=%0d, required rdy=1 rest 0",
                     req_ready, cmp_en, cmp_fun, cmp_a, cmp_b, rsp_valid, rsp_true, rsp_err, op_cnt);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_eq();
        int lat, pulses; logic t, e; logic [3:0] fun; logic [WIDTH-1:0] sa, sb; bit st;
        alu_delay = 0; alu_force = -1;
        run_op(16'd5, 16'd5, 2'd0, 1'b0, 0, lat, t, e, pulses, fun, sa, sb, st);
        ref_cnt++;
        total++;
        if (lat !== 3 || pulses !== 1 || fun !== 4'b1001 || sa !== 16'd5 || sb !== 16'd5) begin
            bad++;
            $display("FAIL eq_issue: lat=%0d pulses=%0d fun=%b a=%0d b=%0d, required 3 1 1001 5 5",
                     lat, pulses, fun, sa, sb);
        end
        total++;
        if (t !== 1'b1 || e !== 1'b0 || op_cnt !== 8'(ref_cnt)) begin
            bad++;
            $display("FAIL eq_rsp: true=%b err=%b cnt=%0d, required 1 0 %0d", t, e, op_cnt, ref_cnt);
        end
    endtask

    task automatic test_gt_lt();
        int lat, pulses; logic t, e; logic [3:0] fun; logic [WIDTH-1:0] sa, sb; bit st;
        alu_delay = 0; alu_force = -1;
        run_op(16'd3, 16'd9, 2'd1, 1'b0, 0, lat, t, e, pulses, fun, sa, sb, st);
        ref_cnt++;
        total++;
        if (t !== 1'b0 || e !== 1'b0 || fun !== 4'b1010 || lat !== 3) begin
            bad++;
            $display("FAIL gt_false: true=%b err=%b fun=%b lat=%0d, required 0 0 1010 3", t, e, fun, lat);
        end
        run_op(16'd3, 16'd9, 2'd2, 1'b0, 0, lat, t, e, pulses, fun, sa, sb, st);
        ref_cnt++;
        total++;
        if (t !== 1'b1 || e !== 1'b0 || fun !== 4'b1011 || op_cnt !== 8'(ref_cnt)) begin
            bad++;
            $display("FAIL lt_true: true=%b err=%b fun=%b cnt=%0d, required 1 0 1011 %0d",
                     t, e, fun, op_cnt, ref_cnt);
        end
    endtask

    task automatic test_reserved();
        int lat, pulses; logic t, e; logic [3:0] fun; logic [WIDTH-1:0] sa, sb; bit st;
        run_op(16'd1, 16'd2, 2'd3, 1'b0, 0, lat, t, e, pulses, fun, sa, sb, st);
        total++;
        if (lat !== 1 || pulses !== 0 || t !== 1'b0 || e !== 1'b1 || op_cnt !== 8'(ref_cnt)) begin
            bad++;
            $display("FAIL reserved_op: lat=%0d pulses=%0d true=%b err=%b cnt=%0d, required 1 0 0 1 %0d",
                     lat, pulses, t, e, op_cnt, ref_cnt);
        end
    endtask

    task automatic test_timeout();
        int lat, pulses; logic t, e; logic [3:0] fun; logic [WIDTH-1:0] sa, sb; bit st;
        alu_delay = -1; alu_force = -1;
        run_op(16'd4, 16'd4, 2'd0, 1'b0, 0, lat, t, e, pulses, fun, sa, sb, st);
        total++;
        if (lat !== 2 + TIMEOUT || e !== 1'b1 || t !== 1'b0 || op_cnt !== 8'(ref_cnt)) begin
            bad++;
            $display("FAIL timeout: lat=%0d err=%b true=%b cnt=%0d, required %0d 1 0 %0d",
                     lat, e, t, op_cnt, 2 + TIMEOUT, ref_cnt);
        end
        alu_delay = 0; alu_force = 7;
        run_op(16'd4, 16'd4, 2'd0, 1'b0, 0, lat, t, e, pulses, fun, sa, sb, st);
        total++;
        if (lat !== 3 || e !== 1'b1 || t !== 1'b0 || op_cnt !== 8'(ref_cnt)) begin
            bad++;
            $display("FAIL bad_code: lat=%0d err=%b true=%b cnt=%0d, required 3 1 0 %0d",
                     lat, e, t, op_cnt, ref_cnt);
        end
        alu_force = -1;
    endtask

    task automatic test_backpressure();
        int lat, pulses; logic t, e; logic [3:0] fun; logic [WIDTH-1:0] sa, sb; bit st, ok;
        alu_delay = 0; alu_force = -1;
        run_op(16'd7, 16'd7, 2'd0, 1'b1, 10, lat, t, e, pulses, fun, sa, sb, st);
        ref_cnt++;
        total++;
        if (!st || t !== 1'b1 || e !== 1'b0) begin
            bad++;
            $display("FAIL hold_stable: stable=%0d true=%b err=%b, required 1 1 0", st, t, e);
        end
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_handshake: rdy=%b vld=%b, required 1 0", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b0 || cmp_en !== 1'b1) begin
            bad++;
            $display("FAIL next_accept: rdy=%b en=%b, required 0 1", req_ready, cmp_en);
        end
        drain(ok);
        ref_cnt++;
        total++;
        if (!ok || op_cnt !== 8'(ref_cnt)) begin
            bad++;
            $display("FAIL second_rsp: ok=%0d cnt=%0d, required 1 %0d", ok, op_cnt, ref_cnt);
        end
    endtask

    task automatic test_random();
        int lat, pulses, dly, frc, elat, nbad; logic t, e, et, ee; logic [3:0] fun;
        logic [WIDTH-1:0] a, b, sa, sb; logic [1:0] op; bit st;
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            b = ($urandom % 3 == 0) ? a : 16'($urandom);
            op = 2'($urandom % 4);
            dly = int'($urandom % 8);
            dly = (dly < 4) ? 0 : (dly < 7) ? dly - 3 : -1;
            frc = ($urandom % 6 == 0) ? int'($urandom % 8) : -1;
            alu_delay = dly; alu_force = frc;
            predict(a, b, op, dly, frc, et, ee, elat);
            run_op(a, b, op, 1'b0, int'($urandom % 3), lat, t, e, pulses, fun, sa, sb, st);
            if (!ee) ref_cnt++;
            nbad = 0;
            if (lat !== elat || t !== et || e !== ee || !st) nbad++;
            if (pulses !== ((op == 2'd3) ? 0 : 1) || fun !== exp_fun(op)) nbad++;
            if (op != 2'd3 && (sa !== a || sb !== b)) nbad++;
            if (op_cnt !== 8'(ref_cnt)) nbad++;
            total++;
            if (nbad != 0) begin
                bad++;
                $display("FAIL random[%0d] op=%0d dly=%0d frc=%0d: lat=%0d t=%b e=%b pulses=%0d fun=%b cnt=%0d, required lat=%0d t=%b e=%b fun=%b cnt=%0d",
                         i, op, dly, frc, lat, t, e, pulses, fun, op_cnt, elat, et, ee, exp_fun(op), ref_cnt & 255);
            end
        end
        alu_delay = 0; alu_force = -1;
    endtask

    task automatic test_reset_wait();
        int lat, pulses, errs; logic t, e; logic [3:0] fun; logic [WIDTH-1:0] sa, sb; bit st, leak;
        alu_delay = -1;
        @(negedge clk);
        req_valid = 1'b1; req_a = 16'd2; req_b = 16'd2; req_op = 2'd0;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (cmp_en !== 1'b0 || rsp_valid !== 1'b0 || op_cnt !== 8'd0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_wait: en=%b vld=%b cnt=%0d rdy=%b, required 0 0 0 1",
                     cmp_en, rsp_valid, op_cnt, req_ready);
        end
        @(negedge clk); rst = 1'b1;
        ref_cnt = 0; alu_delay = 0;
        leak = 1'b0;
        repeat (8) begin @(negedge clk); if (rsp_valid || cmp_en) leak = 1'b1; end
        total++;
        if (leak) begin
            bad++;
            $display("FAIL reset_abort: stray activity=%0d, required 0", leak);
        end
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            alu_delay = int'($urandom % 3);
            run_op(16'(i), 16'(i), 2'd0, 1'b0, 0, lat, t, e, pulses, fun, sa, sb, st);
            if (lat < 0 || e !== 1'b0 || t !== 1'b1) errs++;
        end
        total++;
        if (errs != 0 || op_cnt !== 8'd44) begin
            bad++;
            $display("FAIL wrap_count: errs=%0d cnt=%0d, required 0 44", errs, op_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_eq();
        test_gt_lt();
        test_reserved();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
